// File: rtl/mul_if.sv
// Handshake and operand/result bundle for the iterative signed multiplier.
// master drives operands and start; slave returns product and status.
interface mul_if #(
    parameter int A_WIDTH = 32,
    parameter int B_WIDTH = 32
);
    logic                       valid_in;
    logic [A_WIDTH-1:0]         multiplicand;
    logic [B_WIDTH-1:0]         multiplier;
    logic [A_WIDTH+B_WIDTH-1:0] product;
    logic                       valid_out;
    logic                       busy;

    modport master (
        output valid_in, multiplicand, multiplier,
        input  product, valid_out, busy
    );

    modport slave (
        input  valid_in, multiplicand, multiplier,
        output product, valid_out, busy
    );
endinterface

// File: rtl/mul.sv
// Iterative signed shift-add multiplier, one radix-2 step per clock.
// Magnitudes are multiplied unsigned; the sign is applied in the epilogue.
module mul #(
    parameter int A_WIDTH = 32,
    parameter int B_WIDTH = 32
) (
    input  logic  clk,
    input  logic  reset,
    mul_if.slave  bus
);
    localparam int PW = A_WIDTH + B_WIDTH;
    localparam int CW = $clog2(B_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOOP,
        EPILOGUE
    } state_e;

    state_e             state_q, state_d;
    logic [A_WIDTH-1:0] ma_q, ma_d;
    logic               sign_q, sign_d;
    logic [PW-1:0]      acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [PW-1:0]      product_q, product_d;
    logic               valid_out_q, valid_out_d;

    logic [A_WIDTH-1:0] abs_a;
    logic [B_WIDTH-1:0] abs_b;
    logic [A_WIDTH:0]   upper;

    always_comb begin
        state_d     = state_q;
        ma_d        = ma_q;
        sign_d      = sign_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        product_d   = product_q;
        valid_out_d = 1'b0;
        upper       = '0;

        // |-2^(N-1)| wraps to 2^(N-1), which is correct read as unsigned
        abs_a = bus.multiplicand[A_WIDTH-1]
              ? (~bus.multiplicand + A_WIDTH'(1)) : bus.multiplicand;
        abs_b = bus.multiplier[B_WIDTH-1]
              ? (~bus.multiplier + B_WIDTH'(1)) : bus.multiplier;

        unique case (state_q)
            IDLE: begin
                if (bus.valid_in) begin
                    ma_d    = abs_a;
                    sign_d  = bus.multiplicand[A_WIDTH-1]
                            ^ bus.multiplier[B_WIDTH-1];
                    acc_d   = {{A_WIDTH{1'b0}}, abs_b};
                    cnt_d   = '0;
                    state_d = LOOP;
                end
            end
            LOOP: begin
                upper = {1'b0, acc_q[PW-1:B_WIDTH]};
                if (acc_q[0]) begin
                    upper = upper + {1'b0, ma_q};
                end
                acc_d = {upper, acc_q[B_WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(B_WIDTH - 1)) begin
                    state_d = EPILOGUE;
                end
            end
            EPILOGUE: begin
                product_d   = sign_q ? (~acc_q + PW'(1)) : acc_q;
                valid_out_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ma_q        <= '0;
            sign_q      <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            product_q   <= '0;
            valid_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ma_q        <= ma_d;
            sign_q      <= sign_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            product_q   <= product_d;
            valid_out_q <= valid_out_d;
        end
    end

    assign bus.product   = product_q;
    assign bus.valid_out = valid_out_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_mul.sv
// Self-checking bench for mul: fixed vector table, random operands
// against a plain-arithmetic product model, and handshake corner cases.
module tb_mul;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    mul_if #(.A_WIDTH(32), .B_WIDTH(32)) bus ();

    mul #(.A_WIDTH(32), .B_WIDTH(32)) u_dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa;
        longint sb;
        sa = longint'(int'(a));
        sb = longint'(int'(b));
        return 64'(sa * sb);
    endfunction

    // One operation; operands are scrambled while busy.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [63:0] p, output int lat,
                          output int bcnt, output logic vo_after);
        @(negedge clk);
        bus.valid_in     = 1'b1;
        bus.multiplicand = a;
        bus.multiplier   = b;
        @(negedge clk);
        bus.valid_in     = 1'b0;
        bus.multiplicand = $urandom;
        bus.multiplier   = $urandom;
        lat  = 0;
        bcnt = 0;
        while (!bus.valid_out && lat < 100) begin
            bcnt += int'(bus.busy);
            @(negedge clk);
            lat++;
        end
        bcnt += int'(bus.busy);
        p = bus.product;
        @(negedge clk);
        vo_after = bus.valid_out;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] p;
        int          lat;
        int          bcnt;
        logic        vo;
        int          pulses;
        logic [31:0] ra;
        logic [31:0] rb;

        tbl[0] = '{32'd7,         32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB};
        tbl[1] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        tbl[2] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};
        tbl[3] = '{32'd0,         32'hFFFF_FFFB, 64'h0};
        tbl[4] = '{32'hFFFF_FFFB, 32'd0,         64'h0};
        tbl[5] = '{32'd1,         32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[6] = '{32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000};
        tbl[7] = '{32'h8000_0000, 32'd1,         64'hFFFF_FFFF_8000_0000};
        tbl[8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h1};

        bus.valid_in     = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        repeat (3) @(negedge clk);
        check("reset_product", bus.product, 64'h0);
        check("reset_valid_out", 64'(bus.valid_out), 64'h0);
        check("reset_busy", 64'(bus.busy), 64'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_op(tbl[i].a, tbl[i].b, p, lat, bcnt, vo);
            check($sformatf("tbl%0d_product", i), p, tbl[i].p);
            check($sformatf("tbl%0d_latency", i), 64'(lat), 64'd33);
            check($sformatf("tbl%0d_busy_cycles", i), 64'(bcnt), 64'd33);
            check($sformatf("tbl%0d_pulse_width", i), 64'(vo), 64'h0);
        end

        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 10 == 0) ra = 32'h8000_0000;
            run_op(ra, rb, p, lat, bcnt, vo);
            check($sformatf("rand%0d_product", i), p, model(ra, rb));
            check($sformatf("rand%0d_latency", i), 64'(lat), 64'd33);
        end

        // valid_in pulses while busy must be ignored
        @(negedge clk);
        bus.valid_in     = 1'b1;
        bus.multiplicand = 32'd3;
        bus.multiplier   = 32'd4;
        pulses = 0;
        p      = '0;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (bus.valid_out) begin
                pulses++;
                p = bus.product;
            end
            bus.valid_in     = (c == 5 || c == 20);
            bus.multiplicand = 32'd100;
            bus.multiplier   = 32'd7;
        end
        bus.valid_in = 1'b0;
        check("ignore_pulses", 64'(pulses), 64'd1);
        check("ignore_product", p, 64'd12);

        // valid_in held high: back-to-back operations
        @(negedge clk);
        bus.valid_in     = 1'b1;
        bus.multiplicand = 32'd2;
        bus.multiplier   = 32'd3;
        @(negedge clk);
        lat = 0;
        while (!bus.valid_out && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_first_product", bus.product, 64'd6);
        check("b2b_first_busy", 64'(bus.busy), 64'h0);
        bus.multiplicand = 32'd5;
        bus.multiplier   = 32'hFFFF_FFFA;
        @(negedge clk);
        check("b2b_restart_busy", 64'(bus.busy), 64'h1);
        lat = 0;
        while (!bus.valid_out && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        bus.valid_in = 1'b0;
        check("b2b_second_product", bus.product, 64'hFFFF_FFFF_FFFF_FFE2);
        check("b2b_second_latency", 64'(lat), 64'd33);
        @(negedge clk);
        check("b2b_idle_after", 64'(bus.busy), 64'h0);

        // reset mid-operation aborts it
        @(negedge clk);
        bus.valid_in     = 1'b1;
        bus.multiplicand = 32'd9;
        bus.multiplier   = 32'd9;
        @(negedge clk);
        bus.valid_in = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_product", bus.product, 64'h0);
        check("abort_busy", 64'(bus.busy), 64'h0);
        check("abort_valid_out", 64'(bus.valid_out), 64'h0);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            pulses += int'(bus.valid_out);
        end
        check("abort_no_pulse", 64'(pulses), 64'd0);
        run_op(32'd9, 32'd9, p, lat, bcnt, vo);
        check("after_reset_product", p, 64'd81);
        check("after_reset_latency", 64'(lat), 64'd33);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
